// File: rtl/opmux_pkg.sv
// Shared types and constants for the ID-stage operand mux and its bypass resolvers.
package opmux_pkg;

  localparam int REG_IDX_W = 5;

  // Literal operand for the FOUR select (return address increment).
  localparam logic [2:0] FOUR_VAL = 3'd4;

  typedef enum logic [1:0] {
    RS1     = 2'd0,
    PC      = 2'd1,
    ZERO    = 2'd2,
    RS1_ALT = 2'd3
  } asel_t;

  typedef enum logic [1:0] {
    RS2     = 2'd0,
    IMM     = 2'd1,
    FOUR    = 2'd2,
    RS2_ALT = 2'd3
  } bsel_t;

endpackage

// File: rtl/opmux_stage_byp_resolve.sv
// Priority bypass resolver: the lowest-numbered (youngest) matching channel wins;
// x0 never forwards.
module byp_resolve
  import opmux_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NBYP = 2
) (
  input  logic [REG_IDX_W-1:0]      idx,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [NBYP-1:0]           byp_valid,
  input  logic [NBYP*REG_IDX_W-1:0] byp_rd,
  input  logic [NBYP*XLEN-1:0]      byp_data,
  input  logic [NBYP-1:0]           byp_pend,
  output logic [XLEN-1:0]           fwd_data,
  output logic                      pend_hit
);

  logic [XLEN-1:0] fwd_data_s;
  logic            pend_hit_s;

  // Walk oldest to youngest so the youngest match is the last one to assign.
  always_comb begin
    fwd_data_s = rf_data;
    pend_hit_s = 1'b0;
    for (int i = NBYP - 1; i >= 0; i--) begin
      if (byp_valid[i] && (byp_rd[i*REG_IDX_W +: REG_IDX_W] == idx) &&
          (idx != {REG_IDX_W{1'b0}})) begin
        fwd_data_s = byp_data[i*XLEN +: XLEN];
        pend_hit_s = byp_pend[i];
      end else begin
        fwd_data_s = fwd_data_s;
        pend_hit_s = pend_hit_s;
      end
    end
  end

  assign fwd_data = fwd_data_s;
  assign pend_hit = pend_hit_s;

endmodule

// File: rtl/opmux_stage.sv
// ID-stage operand selection with bypass forwarding, load-use hazard detection
// and a valid/ready ID/EX pipeline register.
module opmux_stage
  import opmux_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NBYP  = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_asel,
  input  logic [1:0]                in_bsel,
  input  logic                      in_rs2_used,
  input  logic [REG_IDX_W-1:0]      in_rs1_idx,
  input  logic [REG_IDX_W-1:0]      in_rs2_idx,
  input  logic [XLEN-1:0]           in_rs1_data,
  input  logic [XLEN-1:0]           in_rs2_data,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [NBYP-1:0]           byp_valid,
  input  logic [NBYP*REG_IDX_W-1:0] byp_rd,
  input  logic [NBYP*XLEN-1:0]      byp_data,
  input  logic [NBYP-1:0]           byp_pend,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_a,
  output logic [XLEN-1:0]           out_b,
  output logic [XLEN-1:0]           out_rs2,
  output logic [XLEN-1:0]           out_pc,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [XLEN-1:0]  rs1_fwd_s, rs2_fwd_s, a_s, b_s;
  logic             rs1_pend_s, rs2_pend_s, hazard_s, in_ready_s, accept_s;
  asel_t            asel_s;
  bsel_t            bsel_s;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_a_r, out_b_r, out_rs2_r, out_pc_r;
  logic [CNT_W-1:0] stall_cnt_r;

  byp_resolve #(.XLEN(XLEN), .NBYP(NBYP)) u_rs1 (
    .idx(in_rs1_idx), .rf_data(in_rs1_data), .byp_valid(byp_valid), .byp_rd(byp_rd),
    .byp_data(byp_data), .byp_pend(byp_pend), .fwd_data(rs1_fwd_s), .pend_hit(rs1_pend_s)
  );

  byp_resolve #(.XLEN(XLEN), .NBYP(NBYP)) u_rs2 (
    .idx(in_rs2_idx), .rf_data(in_rs2_data), .byp_valid(byp_valid), .byp_rd(byp_rd),
    .byp_data(byp_data), .byp_pend(byp_pend), .fwd_data(rs2_fwd_s), .pend_hit(rs2_pend_s)
  );

  assign asel_s   = asel_t'(in_asel);
  assign bsel_s   = bsel_t'(in_bsel);
  // A pending producer only matters if the operand is actually consumed.
  assign hazard_s = in_valid &&
                    ((rs1_pend_s && ((asel_s == RS1) || (asel_s == RS1_ALT))) ||
                     (rs2_pend_s && in_rs2_used));
  assign in_ready_s = rst_n && !flush && !hazard_s && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;

  // Operand A mux.
  always_comb begin
    a_s = {XLEN{1'b0}};
    case (asel_s)
      RS1, RS1_ALT: a_s = rs1_fwd_s;
      PC:           a_s = in_pc;
      ZERO:         a_s = {XLEN{1'b0}};
      default:      a_s = {XLEN{1'b0}};
    endcase
  end

  // Operand B mux.
  always_comb begin
    b_s = {XLEN{1'b0}};
    case (bsel_s)
      RS2, RS2_ALT: b_s = rs2_fwd_s;
      IMM:          b_s = in_imm;
      FOUR:         b_s = {{(XLEN-3){1'b0}}, FOUR_VAL};
      default:      b_s = {XLEN{1'b0}};
    endcase
  end

  // ID/EX pipeline register; flush wins over both accept and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_a_r     <= {XLEN{1'b0}};
      out_b_r     <= {XLEN{1'b0}};
      out_rs2_r   <= {XLEN{1'b0}};
      out_pc_r    <= {XLEN{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_a_r     <= a_s;
      out_b_r     <= b_s;
      out_rs2_r   <= rs2_fwd_s;
      out_pc_r    <= in_pc;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Saturating count of cycles lost to load-use hazards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hazard_s && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign out_rs2   = out_rs2_r;
  assign out_pc    = out_pc_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_opmux_stage.sv
// Directed and randomized bench for opmux_stage against a transaction-level model.
module tb_opmux_stage;

  localparam int XLEN  = 64;
  localparam int NBYP  = 2;
  localparam int CNT_W = 16;
  localparam int SAT   = 65535;

  logic             clk;
  logic             rst_n;
  logic             in_valid, in_ready, in_rs2_used, flush, out_valid, out_ready;
  logic [1:0]       in_asel, in_bsel;
  logic [4:0]       in_rs1_idx, in_rs2_idx;
  logic [XLEN-1:0]  in_rs1_data, in_rs2_data, in_pc, in_imm;
  logic [NBYP-1:0]  byp_valid, byp_pend;
  logic [NBYP*5-1:0]    byp_rd;
  logic [NBYP*XLEN-1:0] byp_data;
  logic [XLEN-1:0]  out_a, out_b, out_rs2, out_pc;
  logic [CNT_W-1:0] stall_cnt;

  logic             bv[NBYP];
  logic [4:0]       brd[NBYP];
  logic [XLEN-1:0]  bdata[NBYP];
  logic             bpend[NBYP];

  assign byp_valid = {bv[1], bv[0]};
  assign byp_rd    = {brd[1], brd[0]};
  assign byp_data  = {bdata[1], bdata[0]};
  assign byp_pend  = {bpend[1], bpend[0]};

  opmux_stage #(.XLEN(XLEN), .NBYP(NBYP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_asel(in_asel), .in_bsel(in_bsel), .in_rs2_used(in_rs2_used),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm), .byp_valid(byp_valid), .byp_rd(byp_rd),
    .byp_data(byp_data), .byp_pend(byp_pend), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rs2(out_rs2), .out_pc(out_pc), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: what EX should currently be seeing.
  bit              m_valid;
  logic [XLEN-1:0] m_a, m_b, m_rs2, m_pc;
  int              m_cnt;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_a = '0; m_b = '0; m_rs2 = '0; m_pc = '0; m_cnt = 0;
  endtask

  // Youngest valid channel writing this register supplies the value; x0 never forwards.
  task automatic ref_fwd(input logic [4:0] idx, input logic [XLEN-1:0] rf,
                         output logic [XLEN-1:0] d, output bit p);
    d = rf;
    p = 1'b0;
    if (idx != 5'd0) begin
      for (int i = 0; i < NBYP; i++) begin
        if (bv[i] && brd[i] == idx) begin
          d = bdata[i];
          p = bpend[i];
          break;
        end
      end
    end
  endtask

  // One clock: check in_ready for the current inputs, advance the model, check registers.
  task automatic cycle();
    logic [XLEN-1:0] f1, f2, ea, eb;
    bit p1, p2, hz, rdy, acc;
    ref_fwd(in_rs1_idx, in_rs1_data, f1, p1);
    ref_fwd(in_rs2_idx, in_rs2_data, f2, p2);
    hz  = in_valid && ((p1 && (in_asel == 2'd0 || in_asel == 2'd3)) || (p2 && in_rs2_used));
    rdy = !flush && !hz && (!m_valid || out_ready);
    acc = in_valid && rdy;
    ea  = (in_asel == 2'd1) ? in_pc  : (in_asel == 2'd2) ? 64'd0 : f1;
    eb  = (in_bsel == 2'd1) ? in_imm : (in_bsel == 2'd2) ? 64'd4 : f2;
    #1;
    chk("in_ready", in_ready, rdy);
    if (hz && !flush && m_cnt < SAT) m_cnt++;
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_a = ea; m_b = eb; m_rs2 = f2; m_pc = in_pc;
    end else if (out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (m_valid) begin
      chk("out_a", out_a, m_a);
      chk("out_b", out_b, m_b);
      chk("out_rs2", out_rs2, m_rs2);
      chk("out_pc", out_pc, m_pc);
    end
  endtask

  task automatic clear_byp();
    for (int i = 0; i < NBYP; i++) begin
      bv[i] = 1'b0; brd[i] = 5'd0; bdata[i] = '0; bpend[i] = 1'b0;
    end
  endtask

  initial begin
    int cnt_hold;
    rst_n = 1'b0; in_valid = 1'b0; in_asel = 2'd0; in_bsel = 2'd0; in_rs2_used = 1'b0;
    in_rs1_idx = 5'd0; in_rs2_idx = 5'd0; in_rs1_data = '0; in_rs2_data = '0;
    in_pc = '0; in_imm = '0; flush = 1'b0; out_ready = 1'b1;
    clear_byp();
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_out_a", out_a, 64'd0);
    chk("rst_out_b", out_b, 64'd0);
    chk("rst_out_rs2", out_rs2, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_stall_cnt", stall_cnt, 64'd0);
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 64'd0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic accept: PC + 4.
    in_valid = 1'b1; in_asel = 2'd1; in_bsel = 2'd2; in_pc = 64'h1000;
    cycle();
    chk("t1_out_a", out_a, 64'h1000);
    chk("t1_out_b", out_b, 64'd4);

    // Forwarding priority: channel 0 beats channel 1; x0 never forwards.
    in_asel = 2'd0; in_rs1_idx = 5'd5; in_rs1_data = 64'h1234;
    bv[0] = 1'b1; bv[1] = 1'b1; brd[0] = 5'd5; brd[1] = 5'd5;
    bdata[0] = 64'hAA; bdata[1] = 64'hBB;
    cycle();
    chk("t2_prio", out_a, 64'hAA);
    in_rs1_idx = 5'd0; brd[0] = 5'd0; brd[1] = 5'd0;
    cycle();
    chk("t2_x0", out_a, 64'h1234);

    // Load-use stall on rs2 for three cycles, then resolve and accept at once.
    clear_byp();
    in_asel = 2'd1; in_bsel = 2'd0; in_rs2_used = 1'b1; in_rs2_idx = 5'd7;
    bv[0] = 1'b1; brd[0] = 5'd7; bpend[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk("t3_stall_ready", in_ready, 64'd0);
      cycle();
    end
    chk("t3_stall_cnt", stall_cnt, 64'd3);
    bpend[0] = 1'b0; bdata[0] = 64'h55;
    cycle();
    chk("t3_out_b", out_b, 64'h55);

    // Back-pressure: hold for four cycles while bypass inputs wander.
    clear_byp();
    in_rs2_used = 1'b0; in_bsel = 2'd1; in_imm = 64'h11; in_pc = 64'h2000;
    cycle();
    out_ready = 1'b0; in_pc = 64'h3000;
    for (int k = 0; k < 4; k++) begin
      bdata[0] = {$urandom, $urandom};
      #1; chk("t4_bp_ready", in_ready, 64'd0);
      cycle();
      chk("t4_hold_a", out_a, 64'h2000);
      chk("t4_hold_valid", out_valid, 64'd1);
    end
    out_ready = 1'b1;
    cycle();
    chk("t4_next_a", out_a, 64'h3000);

    // Flush with a hazard present: valid drops, nothing accepted, no stall counted.
    out_ready = 1'b0; in_asel = 2'd0; in_rs1_idx = 5'd9;
    bv[0] = 1'b1; brd[0] = 5'd9; bpend[0] = 1'b1; flush = 1'b1;
    cycle();
    chk("t5_flush_valid", out_valid, 64'd0);
    chk("t5_flush_cnt", stall_cnt, 64'd3);
    flush = 1'b0; out_ready = 1'b1;
    clear_byp();

    // Randomized traffic with small register indices so matches are frequent.
    for (int n = 0; n < 600; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_asel     = 2'($urandom_range(0, 3));
      in_bsel     = 2'($urandom_range(0, 3));
      in_rs2_used = $urandom_range(0, 1) == 1;
      in_rs1_idx  = 5'($urandom_range(0, 3));
      in_rs2_idx  = 5'($urandom_range(0, 3));
      in_rs1_data = {$urandom, $urandom};
      in_rs2_data = {$urandom, $urandom};
      in_pc       = {$urandom, $urandom};
      in_imm      = {$urandom, $urandom};
      for (int i = 0; i < NBYP; i++) begin
        bv[i]    = $urandom_range(0, 1) == 1;
        brd[i]   = 5'($urandom_range(0, 3));
        bdata[i] = {$urandom, $urandom};
        bpend[i] = ($urandom_range(0, 4) == 0);
      end
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Saturation under a sustained hazard.
    clear_byp(); flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_asel = 2'd0; in_rs1_idx = 5'd3;
    bv[0] = 1'b1; brd[0] = 5'd3; bpend[0] = 1'b1;
    cycle();
    repeat (65540) @(posedge clk);
    #1;
    m_cnt = (m_cnt + 65540 > SAT) ? SAT : m_cnt + 65540;
    m_valid = 1'b0;
    chk("t6_sat", stall_cnt, 64'hFFFF);
    cycle();
    chk("t6_sat_hold", stall_cnt, 64'hFFFF);

    // Asynchronous reset mid-transfer.
    clear_byp();
    in_asel = 2'd1; in_pc = 64'h4000; out_ready = 1'b0;
    cycle();
    chk("t6_pre_valid", out_valid, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 64'd0);
    chk("t6_async_cnt", stall_cnt, 64'd0);
    chk("t6_async_a", out_a, 64'd0);
    chk("t6_async_ready", in_ready, 64'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1; in_pc = 64'h5000;
    cycle();
    chk("t6_after_rst_a", out_a, 64'h5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
